// File: rtl/cve2_mem_arbiter_pkg.sv
// Shared types for the instruction/data memory port arbiter.
package cve2_mem_arbiter_pkg;

  typedef enum logic {
    MEM_SRC_INSTR = 1'b0,
    MEM_SRC_DATA  = 1'b1
  } mem_src_e;

  // Fetches always read a full word.
  localparam logic [3:0] InstrBe = 4'hF;

endpackage

// File: rtl/cve2_arb_id_fifo.sv
// Small FIFO of requester IDs for accepted-but-unanswered transactions.
module cve2_arb_id_fifo #(
  parameter int unsigned Depth = 2,
  parameter type         T     = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  T     data_i,
  input  logic pop_i,
  output T     head_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

  T                mem_q [Depth];
  T                mem_d [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Explicit wrap so non-power-of-2 depths work.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_i) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop_i) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    unique case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '{default: T'(0)};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  push_not_full_a: assert property (@(posedge clk_i) disable iff (!rst_ni) push_i |-> !full_o);
  pop_not_empty_a: assert property (@(posedge clk_i) disable iff (!rst_ni) pop_i |-> !empty_o);

endmodule

// File: rtl/cve2_mem_arbiter.sv
// Shares one OBI memory port between instruction fetch and LSU. Data has priority;
// instr is forced through after StarveLimit consecutive losses.
module cve2_mem_arbiter
  import cve2_mem_arbiter_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned StarveLimit    = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i,
  output logic        busy_o
);

  localparam int unsigned StarveW = $clog2(StarveLimit + 1);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(StarveLimit);

  mem_src_e           sel;
  mem_src_e           owner_q, owner_d;
  mem_src_e           fifo_head;
  logic               lock_q, lock_d;
  logic [StarveW-1:0] starve_q, starve_d;
  logic               fifo_full, fifo_empty, fifo_pop;
  logic               req, accept, gnt_instr;

  // A stalled request keeps its source until granted, regardless of priority.
  always_comb begin
    if (lock_q) begin
      sel = owner_q;
    end else if (data_req_i && !(instr_req_i && (starve_q == StarveMax))) begin
      sel = MEM_SRC_DATA;
    end else begin
      sel = MEM_SRC_INSTR;
    end
  end

  always_comb begin
    req       = ((sel == MEM_SRC_DATA) ? data_req_i : instr_req_i) & ~fifo_full;
    accept    = req & mem_gnt_i;
    gnt_instr = accept & (sel == MEM_SRC_INSTR);
    fifo_pop  = mem_rvalid_i & ~fifo_empty;
    lock_d    = req & ~mem_gnt_i;
    owner_d   = sel;
    starve_d  = starve_q;
    if (!instr_req_i || gnt_instr) begin
      starve_d = '0;
    end else if (starve_q != StarveMax) begin
      starve_d = starve_q + StarveW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q   <= 1'b0;
      owner_q  <= MEM_SRC_INSTR;
      starve_q <= '0;
    end else begin
      lock_q   <= lock_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
    end
  end

  cve2_arb_id_fifo #(
    .Depth(MaxOutstanding),
    .T    (mem_src_e)
  ) u_id_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (accept),
    .data_i (sel),
    .pop_i  (fifo_pop),
    .head_o (fifo_head),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  // Outputs are forced low while reset is asserted.
  always_comb begin
    mem_req_o      = req;
    mem_we_o       = 1'b0;
    mem_be_o       = InstrBe;
    mem_addr_o     = instr_addr_i;
    mem_wdata_o    = '0;
    if (sel == MEM_SRC_DATA) begin
      mem_we_o    = data_we_i;
      mem_be_o    = data_be_i;
      mem_addr_o  = data_addr_i;
      mem_wdata_o = data_wdata_i;
    end
    instr_gnt_o    = gnt_instr;
    data_gnt_o     = accept & (sel == MEM_SRC_DATA);
    instr_rvalid_o = fifo_pop & (fifo_head == MEM_SRC_INSTR);
    data_rvalid_o  = fifo_pop & (fifo_head == MEM_SRC_DATA);
    instr_rdata_o  = mem_rdata_i;
    data_rdata_o   = mem_rdata_i;
    instr_err_o    = mem_err_i;
    data_err_o     = mem_err_i;
    busy_o         = ~fifo_empty | lock_q | instr_req_i | data_req_i;
    if (!rst_ni) begin
      mem_req_o      = 1'b0;
      mem_we_o       = 1'b0;
      mem_be_o       = '0;
      mem_addr_o     = '0;
      mem_wdata_o    = '0;
      instr_gnt_o    = 1'b0;
      data_gnt_o     = 1'b0;
      instr_rvalid_o = 1'b0;
      data_rvalid_o  = 1'b0;
      instr_rdata_o  = '0;
      data_rdata_o   = '0;
      instr_err_o    = 1'b0;
      data_err_o     = 1'b0;
      busy_o         = 1'b0;
    end
  end

  payload_stable_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (mem_req_o && !mem_gnt_i) |=>
      (mem_req_o && $stable({mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o})));

  rvalid_expected_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    mem_rvalid_i |-> !fifo_empty);

endmodule

// File: tb/tb_cve2_mem_arbiter.sv
// Self-checking bench for cve2_mem_arbiter: directed vector table, reset sequence, random OBI traffic.
module tb_cve2_mem_arbiter;

  localparam int MaxOut = 2;
  localparam int Starve = 4;
  localparam logic [31:0] IADDR  = 32'h0000_1000;
  localparam logic [31:0] DADDR  = 32'h2000_0040;
  localparam logic [31:0] DWDATA = 32'hCAFE_F00D;
  localparam logic [3:0]  DBE    = 4'b0011;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        instr_req_i, instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0] instr_addr_i, instr_rdata_o;
  logic        data_req_i, data_we_i, data_gnt_o, data_rvalid_o, data_err_o;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
  logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i, mem_err_i;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic        busy_o;

  always #5 clk_i = ~clk_i;

  cve2_mem_arbiter #(
    .MaxOutstanding(MaxOut),
    .StarveLimit   (Starve)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .instr_req_i   (instr_req_i),
    .instr_addr_i  (instr_addr_i),
    .instr_gnt_o   (instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o),
    .instr_rdata_o (instr_rdata_o),
    .instr_err_o   (instr_err_o),
    .data_req_i    (data_req_i),
    .data_we_i     (data_we_i),
    .data_be_i     (data_be_i),
    .data_addr_i   (data_addr_i),
    .data_wdata_i  (data_wdata_i),
    .data_gnt_o    (data_gnt_o),
    .data_rvalid_o (data_rvalid_o),
    .data_rdata_o  (data_rdata_o),
    .data_err_o    (data_err_o),
    .mem_req_o     (mem_req_o),
    .mem_we_o      (mem_we_o),
    .mem_be_o      (mem_be_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_gnt_i     (mem_gnt_i),
    .mem_rvalid_i  (mem_rvalid_i),
    .mem_rdata_i   (mem_rdata_i),
    .mem_err_i     (mem_err_i),
    .busy_o        (busy_o)
  );

  typedef struct packed {
    bit rst, ireq, dreq, dwe, gnt, rv, err;
    bit x_req, x_igt, x_dgt, x_irv, x_drv, x_busy, x_sel;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: pending owner (-1 none, 0 instr, 1 data), loss streak, outstanding queue.
  int owner;
  int losses;
  int q[$];
  logic e_req, e_igt, e_dgt, e_irv, e_drv, e_busy;
  int e_sel;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    owner  = -1;
    losses = 0;
    q.delete();
  endfunction

  function automatic void model_eval();
    int sel;
    if (owner >= 0) sel = owner;
    else if (data_req_i && !(instr_req_i && losses == Starve)) sel = 1;
    else sel = 0;
    e_sel  = sel;
    e_req  = ((sel == 1) ? data_req_i : instr_req_i) && (q.size() < MaxOut);
    e_igt  = e_req && mem_gnt_i && (sel == 0);
    e_dgt  = e_req && mem_gnt_i && (sel == 1);
    e_irv  = mem_rvalid_i && (q.size() > 0) && (q[0] == 0);
    e_drv  = mem_rvalid_i && (q.size() > 0) && (q[0] == 1);
    e_busy = (q.size() > 0) || (owner >= 0) || instr_req_i || data_req_i;
  endfunction

  function automatic void model_commit();
    if (mem_rvalid_i && q.size() > 0) void'(q.pop_front());
    if (e_req && mem_gnt_i) q.push_back(e_sel);
    owner = (e_req && !mem_gnt_i) ? e_sel : -1;
    if (!instr_req_i || e_igt) losses = 0;
    else if (losses < Starve) losses++;
  endfunction

  task automatic clear_inputs();
    instr_req_i  = 1'b0;
    instr_addr_i = IADDR;
    data_req_i   = 1'b0;
    data_we_i    = 1'b0;
    data_be_i    = DBE;
    data_addr_i  = DADDR;
    data_wdata_i = DWDATA;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    mem_err_i    = 1'b0;
  endtask

  // Called at posedge+1; leaves time at posedge+1 of the first active cycle.
  task automatic do_reset();
    rst_ni = 1'b0;
    clear_inputs();
    model_reset();
    #3;
    check("reset ctrl", 32'({mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o,
                             data_rvalid_o, busy_o}), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  task automatic cycle(input bit use_tbl, input vec_t v, input string tag);
    logic x_req, x_igt, x_dgt, x_irv, x_drv, x_busy, x_sel;
    model_eval();
    if (use_tbl) begin
      {x_req, x_igt, x_dgt, x_irv, x_drv, x_busy, x_sel} =
        {v.x_req, v.x_igt, v.x_dgt, v.x_irv, v.x_drv, v.x_busy, v.x_sel};
    end else begin
      {x_req, x_igt, x_dgt, x_irv, x_drv, x_busy} = {e_req, e_igt, e_dgt, e_irv, e_drv, e_busy};
      x_sel = (e_sel == 1);
    end
    #3;
    check({tag, " mem_req"}, 32'(mem_req_o), 32'(x_req));
    check({tag, " instr_gnt"}, 32'(instr_gnt_o), 32'(x_igt));
    check({tag, " data_gnt"}, 32'(data_gnt_o), 32'(x_dgt));
    check({tag, " instr_rvalid"}, 32'(instr_rvalid_o), 32'(x_irv));
    check({tag, " data_rvalid"}, 32'(data_rvalid_o), 32'(x_drv));
    check({tag, " busy"}, 32'(busy_o), 32'(x_busy));
    if (x_req) begin
      check({tag, " addr"}, mem_addr_o, x_sel ? data_addr_i : instr_addr_i);
      check({tag, " we"}, 32'(mem_we_o), x_sel ? 32'(data_we_i) : 32'd0);
      check({tag, " be"}, 32'(mem_be_o), x_sel ? 32'(data_be_i) : 32'hF);
      if (x_sel) check({tag, " wdata"}, mem_wdata_o, data_wdata_i);
    end
    if (x_irv) begin
      check({tag, " instr_rdata"}, instr_rdata_o, mem_rdata_i);
      check({tag, " instr_err"}, 32'(instr_err_o), 32'(mem_err_i));
    end
    if (x_drv) begin
      check({tag, " data_rdata"}, data_rdata_o, mem_rdata_i);
      check({tag, " data_err"}, 32'(data_err_o), 32'(mem_err_i));
    end
    @(posedge clk_i);
    model_commit();
    #1;
  endtask

  function automatic vec_t mk(bit rst, bit i, bit d, bit we, bit g, bit rv, bit er,
                              bit xr, bit xig, bit xdg, bit xir, bit xdr, bit xb, bit xs);
    vec_t v;
    v = {rst, i, d, we, g, rv, er, xr, xig, xdg, xir, xdr, xb, xs};
    return v;
  endfunction

  vec_t tbl[$];
  vec_t nov;
  bit   ip, dp;

  initial begin
    nov = '0;
    clear_inputs();
    model_reset();
    //         rst i d we g rv er | req igt dgt irv drv busy sel
    // Starvation: both requesting, grant every cycle, response one cycle later.
    tbl.push_back(mk(1, 1, 1, 0, 1, 0, 0, 1, 0, 1, 0, 0, 1, 1));
    tbl.push_back(mk(0, 1, 1, 0, 1, 1, 0, 1, 0, 1, 0, 1, 1, 1));
    tbl.push_back(mk(0, 1, 1, 0, 1, 1, 0, 1, 0, 1, 0, 1, 1, 1));
    tbl.push_back(mk(0, 1, 1, 0, 1, 1, 0, 1, 0, 1, 0, 1, 1, 1));
    tbl.push_back(mk(0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 1, 1, 0, 1, 1, 0, 1, 0, 1, 1, 0, 1, 1));
    tbl.push_back(mk(0, 1, 1, 0, 1, 1, 0, 1, 0, 1, 0, 1, 1, 1));
    tbl.push_back(mk(0, 1, 1, 0, 1, 1, 0, 1, 0, 1, 0, 1, 1, 1));
    tbl.push_back(mk(0, 1, 1, 0, 1, 1, 0, 1, 0, 1, 0, 1, 1, 1));
    tbl.push_back(mk(0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Instr locked for 3 cycles while data arrives; data error response.
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 1, 1, 1, 0, 0, 1, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 1, 1, 1, 0, 1, 0, 1, 1, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // FIFO full blocks the third request, even in the cycle of a response.
    tbl.push_back(mk(1, 0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    @(posedge clk_i);
    #1;
    foreach (tbl[n]) begin
      if (tbl[n].rst) do_reset();
      instr_req_i  = tbl[n].ireq;
      instr_addr_i = IADDR;
      data_req_i   = tbl[n].dreq;
      data_we_i    = tbl[n].dwe;
      data_be_i    = DBE;
      data_addr_i  = DADDR;
      data_wdata_i = DWDATA;
      mem_gnt_i    = tbl[n].gnt;
      mem_rvalid_i = tbl[n].rv;
      mem_rdata_i  = 32'hA5A5_0000 + 32'(n);
      mem_err_i    = tbl[n].err;
      cycle(1'b1, tbl[n], $sformatf("vec%0d", n));
    end

    // Reset with two outstanding: outputs drop at once, FIFO is flushed.
    do_reset();
    data_req_i = 1'b1;
    mem_gnt_i  = 1'b1;
    cycle(1'b0, nov, "rs0");
    cycle(1'b0, nov, "rs1");
    instr_req_i  = 1'b1;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hFFFF_FFFF;
    mem_err_i    = 1'b1;
    rst_ni       = 1'b0;
    #1;
    check("rst ctrl", 32'({mem_req_o, mem_we_o, instr_gnt_o, data_gnt_o, instr_rvalid_o,
                           data_rvalid_o, instr_err_o, data_err_o, busy_o}), 32'd0);
    check("rst payload", 32'(|{mem_be_o, mem_addr_o, mem_wdata_o}), 32'd0);
    check("rst rdata", 32'(|{instr_rdata_o, data_rdata_o}), 32'd0);
    @(posedge clk_i);
    #1;
    clear_inputs();
    model_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    check("post-rst busy", 32'(busy_o), 32'd0);
    check("post-rst req", 32'(mem_req_o), 32'd0);
    @(posedge clk_i);
    #1;
    instr_req_i = 1'b1;
    mem_gnt_i   = 1'b1;
    cycle(1'b0, nov, "pr0");
    instr_req_i  = 1'b0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h1234_5678;
    cycle(1'b0, nov, "pr1");
    mem_rvalid_i = 1'b0;
    cycle(1'b0, nov, "pr2");

    // Random OBI-compliant traffic against the reference model.
    do_reset();
    ip = 1'b0;
    dp = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (!ip && ($urandom_range(0, 2) != 0)) begin
        ip           = 1'b1;
        instr_addr_i = $urandom() & 32'hFFFF_FFFC;
      end
      if (!dp && ($urandom_range(0, 2) != 0)) begin
        dp           = 1'b1;
        data_addr_i  = $urandom();
        data_we_i    = 1'($urandom_range(0, 1));
        data_be_i    = 4'($urandom_range(1, 15));
        data_wdata_i = $urandom();
      end
      instr_req_i  = ip;
      data_req_i   = dp;
      mem_gnt_i    = ($urandom_range(0, 3) != 0);
      mem_rvalid_i = (q.size() > 0) && ($urandom_range(0, 1) == 1);
      mem_rdata_i  = $urandom();
      mem_err_i    = ($urandom_range(0, 7) == 0);
      cycle(1'b0, nov, $sformatf("rnd%0d", k));
      if (e_igt) ip = 1'b0;
      if (e_dgt) dp = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
